// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory address/data, execute redirect,
// and the valid/ready instruction stream toward decode.
interface instr_fetch_unit_if;
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_misaligned;

  // Fetch unit side
  modport master (
    output mem_addr,
    input  mem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output out_misaligned
  );

  // Memory / execute / decode side
  modport slave (
    input  mem_addr,
    output mem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  out_misaligned
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches to a synchronous
// memory that reads every cycle, tags returning data with its PC, and buffers
// up to two responses so decode back-pressure never loses a word. A redirect
// flushes the in-flight read and the buffer and restarts at the target.
// Optional macro IFU_ALIGN_CHECK_EN: misaligned redirect targets are forced to
// word alignment and the first instruction fetched there is flagged.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);
  localparam int unsigned XLEN  = 32;
  localparam logic [2:0]  DEPTH = 3'(BUF_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misaligned;
  } fetch_entry_t;

  logic [XLEN-1:0] pc_q;
  logic            req_valid;
  logic [XLEN-1:0] req_pc;
  logic            req_mis;
  logic            mis_pending;

  // Shift-style buffer: slot 0 is always the head, so outputs come straight
  // from registers and stay stable while decode stalls.
  fetch_entry_t    head_q, tail_q, head_d, tail_d;
  logic            head_vld, tail_vld, head_vld_d, tail_vld_d;

  logic            redirect;
  logic            pop;
  logic            push;
  logic            issue;
  logic [1:0]      count;
  logic [XLEN-1:0] redirect_target;
  logic            redirect_mis;
  fetch_entry_t    rsp_entry;

  assign redirect = bus.redirect_valid;
  assign count    = 2'(head_vld) + 2'(tail_vld);
  assign pop      = head_vld & bus.out_ready;
  assign push     = req_valid & ~redirect;
  // Issue only when the buffer can absorb this read plus the one in flight.
  assign issue    = ~redirect & ((3'(count) + 3'(req_valid)) < (DEPTH + 3'(pop)));

`ifdef IFU_ALIGN_CHECK_EN
  assign redirect_target = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign redirect_mis    = |bus.redirect_pc[1:0];
`else
  assign redirect_target = bus.redirect_pc;
  assign redirect_mis    = 1'b0;
`endif

  assign rsp_entry = {req_pc, bus.mem_rdata, req_mis};

  assign bus.mem_addr       = pc_q;
  assign bus.out_valid      = head_vld;
  assign bus.out_pc         = head_q.pc;
  assign bus.out_instr      = head_q.instr;
  assign bus.out_misaligned = head_q.misaligned;

  // Fetch PC, in-flight request tracking and misaligned-target tagging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_valid   <= 1'b0;
      req_pc      <= '0;
      req_mis     <= 1'b0;
      mis_pending <= 1'b0;
    end else if (redirect) begin
      pc_q        <= redirect_target;
      req_valid   <= 1'b0;
      mis_pending <= redirect_mis;
    end else if (issue) begin
      pc_q        <= pc_q + XLEN'(4);
      req_valid   <= 1'b1;
      req_pc      <= pc_q;
      req_mis     <= mis_pending;
      mis_pending <= 1'b0;
    end else begin
      req_valid   <= 1'b0;
    end
  end

  // Response buffer next state: flush on redirect, else pop then push.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    head_vld_d = head_vld;
    tail_vld_d = tail_vld;
    if (redirect) begin
      head_vld_d = 1'b0;
      tail_vld_d = 1'b0;
    end else begin
      if (pop) begin
        if (tail_vld) begin
          head_d = tail_q;
        end
        head_vld_d = tail_vld;
        tail_vld_d = 1'b0;
      end
      if (push) begin
        if (!head_vld_d) begin
          head_d     = rsp_entry;
          head_vld_d = 1'b1;
        end else begin
          tail_d     = rsp_entry;
          tail_vld_d = 1'b1;
        end
      end
    end
  end

  // Response buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      head_vld <= 1'b0;
      tail_vld <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      head_vld <= head_vld_d;
      tail_vld <= tail_vld_d;
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch-side initiator for the core's synchronous instruction memory. Drives word addresses into the memory's `addr` port and tags the data returned one cycle later with its PC. Presents instructions to decode through a valid/ready handshake. Absorbs back-pressure with a 2-entry response buffer, because the memory has no read enable and reads every cycle. Handles PC redirects from execute (branches, jumps, traps) by flushing all in-flight and buffered fetches.

## Interface
Parameters:
- `RESET_PC`, 32'h80000000, first fetch address after reset.
- `BUF_DEPTH`, 2, response buffer entries; fixed at 2, other values unsupported.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset is asynchronous and active-high.
- `mem_addr` out 32: byte address to the instruction memory; equals `pc_q` every cycle.
- `mem_rdata` in 32: little-endian word; valid the cycle after the address was presented.
- `redirect_valid` in 1: load a new fetch PC.
- `redirect_pc` in 32: target PC, sampled when `redirect_valid` = 1.
- `out_valid` out 1: instruction available to decode.
- `out_ready` in 1: decode accepts the instruction this cycle.
- `out_pc` out 32: PC of the presented instruction.
- `out_instr` out 32: instruction word.
- `out_misaligned` out 1: presented entry came from a misaligned redirect (see Configuration).

## Operation
- State:
  - `pc_q`: next address to issue.
  - `req_valid` / `req_pc`: one in-flight read.
  - 2-entry FIFO of {pc, instr, misaligned}, with count 0..2.
- Pop: `out_valid && out_ready`. Outputs show the FIFO head; `out_valid = (count != 0)`.
- Credit: `2 - count - req_valid + pop`. An issue happens iff credit > 0 and there is no redirect.
- On issue:
  - `req_valid <= 1`, `req_pc <= pc_q`, `pc_q <= pc_q + 4` (mod 2^32, wraps from 32'hFFFFFFFC to 0).
  - Otherwise `req_valid <= 0` and `pc_q` holds. The memory still reads `pc_q`, and that data is discarded.
- When `req_valid` = 1, {`req_pc`, `mem_rdata`} is pushed into the FIFO at the next edge.
- The FIFO never overflows under any `out_ready` pattern.
- Redirect has priority over everything. At the edge where `redirect_valid` = 1:
  - FIFO count becomes 0 and `req_valid` becomes 0; the returning word is dropped.
  - `pc_q <= redirect_pc`.
  - A pop completing in the same cycle counts as a delivered instruction.
- Redirect while stalled or while the FIFO is full behaves identically: everything is flushed.
- Back-to-back redirects: the last one wins.
- While `out_valid` = 1 and `out_ready` = 0, `out_pc`, `out_instr` and `out_misaligned` stay stable until the pop or a redirect.

## Timing
- Reset values: `pc_q` = `mem_addr` = RESET_PC; `req_valid` = 0; FIFO count = 0; `out_valid` = 0; `out_pc` = 0; `out_instr` = 0; `out_misaligned` = 0.
- Reset applies asynchronously mid-operation. It discards all state and restarts at RESET_PC.
- Latency:
  - Edge 1 after `rst` deasserts: issue of RESET_PC.
  - Edge 2: push; `out_valid` = 1 from then on.
  - After a redirect at edge N: first `out_valid` after edge N+2, with `out_pc` = target.
- Throughput: one instruction per cycle while `out_ready` = 1. Steady state is count = 1 with one read in flight.
- Stall: when `out_ready` drops, at most 2 entries are held and issue stops. After `out_ready` rises, the first instruction is delivered in that cycle and the stream continues without a bubble.

## Configuration
- Macro `IFU_ALIGN_CHECK_EN`.
- Defined: when a redirect has `redirect_pc[1:0]` != 0:
  - `pc_q` loads `{redirect_pc[31:2], 2'b00}`.
  - The first entry delivered after that redirect has `out_misaligned` = 1 and `out_pc` = `{redirect_pc[31:2], 2'b00}`.
  - Later entries have `out_misaligned` = 0.
- Not defined:
  - `redirect_pc` is used unmodified; the byte-addressed memory returns the unaligned word.
  - `out_misaligned` is tied to 0.
  - The increment stays +4.

## Test plan
- Reset with `out_ready` = 1, release → `out_valid` rises after edge 2. Delivered PCs are 80000000, 80000004, 80000008 on consecutive cycles, and each instruction matches the memory image.
- Hold `out_ready` = 0 for 5 cycles mid-stream (head 80000010) → the outputs hold 80000010. After release, 80000010 then 80000014 are delivered back-to-back with none skipped or duplicated.
- Redirect to 80000100 while 2 entries are buffered → no stale PC is delivered. The next delivered `out_pc` is 80000100, two cycles later.
- Pop of 80000008 and a redirect to 80000040 in the same cycle → 80000008 counts as delivered, and the next delivered PC is 80000040.
- Assert `rst` mid-stream for 1 cycle → outputs return to their reset values immediately, and delivery restarts at 80000000.
- With `IFU_ALIGN_CHECK_EN` defined, redirect to 80000022 → the first delivered entry has `out_pc` = 80000020 and `out_misaligned` = 1. The next entry has 80000024 and `out_misaligned` = 0.
